arm_cpu_core: RTL and testbench
===============================

ARM_CPU_CORE -- requirements
Module: arm_cpu_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; CLOCK and RESET are the port names.
REQ-002 CLOCK  input  1  system clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high; clears PC and register file.
REQ-004 IC  input  32  instruction word fetched from the instruction memory at PC.
REQ-005 mem_data_out  input  32  read data returned by the data memory, combinational.
REQ-006 PC  output  32  byte address of the current instruction.
REQ-007 mem_address  output  32  data memory byte address.
REQ-008 mem_data_in  output  32  store data driven to the data memory.
REQ-009 control_memwrite  output  1  data memory write enable, LDUR/STUR datapath only.
REQ-010 control_memread  output  1  data memory read enable.

Function
REQ-011 The core SHALL be a single-cycle, 32-bit LEGv8-subset processor: each instruction completes in exactly one CLOCK cycle.
REQ-012 The register file SHALL hold 32 x 32-bit registers X0-X31.
REQ-013 X31 (XZR) SHALL read as 0, and writes to it SHALL be discarded.
REQ-014 Register reads SHALL be combinational; the write occurs on the rising edge.
REQ-015 Field slices: Rd=IC[4:0], Rn=IC[9:5], Rm=IC[20:16], ALU_imm=IC[21:10] (zero-extended), DT_addr=IC[20:12] (sign-extended), CB_addr=IC[23:5] (sign-extended), B_addr=IC[25:0] (sign-extended).
REQ-016 ADD (IC[31:21]=10001011000) SHALL write Rd = Rn + Rm.
REQ-017 SUB (11001011000) SHALL write Rd = Rn - Rm.
REQ-018 AND (10001010000) SHALL write Rd = Rn & Rm.
REQ-019 ORR (10101010000) SHALL write Rd = Rn | Rm.
REQ-020 ADDI (IC[31:22]=1001000100) SHALL write Rd = Rn + ALU_imm.
REQ-021 SUBI (1101000100) SHALL write Rd = Rn - ALU_imm.
REQ-022 All arithmetic SHALL be modulo 2^32; there are no flags and no overflow trap.
REQ-023 LDUR (11111000010) SHALL write Rd = mem_data_out, with mem_address = Rn + DT_addr and control_memread=1.
REQ-024 STUR (11111000000) SHALL drive mem_address = Rn + DT_addr, mem_data_in = register[Rd] and control_memwrite=1, with no register write.
REQ-025 CBZ (IC[31:24]=10110100) SHALL set next PC = PC + (CB_addr<<2) if register[Rd]==0, else PC+4.
REQ-026 B (IC[31:26]=000101) SHALL set next PC = PC + (B_addr<<2) unconditionally.
REQ-027 For all other instructions, next PC SHALL be PC+4, wrapping modulo 2^32.
REQ-028 Any unrecognised encoding SHALL execute as a NOP: PC+4, no register write, both memory enables 0.
REQ-029 control_memread and control_memwrite SHALL never both be 1.
REQ-030 mem_address SHALL equal the ALU result for all instructions; mem_data_in SHALL always equal register[Rd].
REQ-031 Companion data memory (Data_Memory): reads are combinational when memread=1, and writes are performed on the write-enable level by address.
REQ-032 Companion IC module: a combinational ROM indexed by PC.

Reset
REQ-033 While RESET=1, PC SHALL be 0 and all registers 0, asynchronously; no register or memory write occurs.
REQ-034 After RESET deasserts, the first rising edge SHALL execute the instruction at PC=0.
REQ-035 Asserting RESET mid-program SHALL immediately force PC=0 and clear the registers, regardless of CLOCK.

Verification
REQ-036 Reset: RESET=1 for 1 cycle -> PC=0, X0..X30=0, control_memwrite=0.
REQ-037 ADDI X1,XZR,#5 then ADDI X2,XZR,#3 then SUB X3,X1,X2 -> X3=2, PC=12 after 3 edges.
REQ-038 STUR X1,[X2,#4] with X1=5, X2=3 -> mem_address=7, mem_data_in=5, control_memwrite=1; then LDUR X4,[X2,#4] -> X4=5, control_memread=1.
REQ-039 CBZ X0,#3 at PC=16 -> next PC=28; CBZ X1,#3 with X1=5 -> next PC=20.
REQ-040 B #-2 at PC=24 -> next PC=16.
REQ-041 ADD XZR,X1,X1 -> XZR still reads 0; SUBI X5,XZR,#1 -> X5=0xFFFFFFFF.

Source files
------------

// File: rtl/arm_cpu_core.sv
// Single-cycle 32-bit LEGv8-subset core: decode, register file, ALU,
// next-PC logic and data-memory handshake, all resolved within one clock.
module arm_cpu_core (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] IC,
  input  logic [31:0] mem_data_out,
  output logic [31:0] PC,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        control_memwrite,
  output logic        control_memread
);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI,
    OP_SUBI, OP_LDUR, OP_STUR, OP_CBZ, OP_B
  } op_e;

  op_e                op;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        regs_q [32];
  logic [4:0]         rd_idx, rn_idx, rm_idx;
  logic [31:0]        rd_val, rn_val, rm_val;
  logic [31:0]        imm_alu;
  logic signed [31:0] dt_off, cb_off, b_off;
  logic [31:0]        alu_res;
  logic [31:0]        wb_data;
  logic               wb_en;

  // Instruction fields; branch offsets are already scaled to bytes.
  assign rd_idx  = IC[4:0];
  assign rn_idx  = IC[9:5];
  assign rm_idx  = IC[20:16];
  assign imm_alu = {20'b0, IC[21:10]};
  assign dt_off  = {{23{IC[20]}}, IC[20:12]};
  assign cb_off  = {{11{IC[23]}}, IC[23:5], 2'b00};
  assign b_off   = {{4{IC[25]}}, IC[25:0], 2'b00};

  // X31 is the zero register: it always reads 0 regardless of storage.
  assign rd_val = (rd_idx == 5'd31) ? 32'd0 : regs_q[rd_idx];
  assign rn_val = (rn_idx == 5'd31) ? 32'd0 : regs_q[rn_idx];
  assign rm_val = (rm_idx == 5'd31) ? 32'd0 : regs_q[rm_idx];

  // Opcode decode; anything not listed falls through to NOP.
  always_comb begin
    op = OP_NOP;
    if      (IC[31:21] == 11'b10001011000) op = OP_ADD;
    else if (IC[31:21] == 11'b11001011000) op = OP_SUB;
    else if (IC[31:21] == 11'b10001010000) op = OP_AND;
    else if (IC[31:21] == 11'b10101010000) op = OP_ORR;
    else if (IC[31:21] == 11'b11111000010) op = OP_LDUR;
    else if (IC[31:21] == 11'b11111000000) op = OP_STUR;
    else if (IC[31:22] == 10'b1001000100)  op = OP_ADDI;
    else if (IC[31:22] == 10'b1101000100)  op = OP_SUBI;
    else if (IC[31:24] == 8'b10110100)     op = OP_CBZ;
    else if (IC[31:26] == 6'b000101)       op = OP_B;
  end

  // ALU: modulo-2^32 arithmetic/logic; ld/st use it for address generation.
  always_comb begin
    alu_res = rn_val + rm_val;
    case (op)
      OP_SUB:           alu_res = rn_val - rm_val;
      OP_AND:           alu_res = rn_val & rm_val;
      OP_ORR:           alu_res = rn_val | rm_val;
      OP_ADDI:          alu_res = rn_val + imm_alu;
      OP_SUBI:          alu_res = rn_val - imm_alu;
      OP_LDUR, OP_STUR: alu_res = rn_val + dt_off;
      default:          alu_res = rn_val + rm_val;
    endcase
  end

  // Next-PC selection: CBZ tests register[Rd], B is unconditional.
  always_comb begin
    pc_d = pc_q + 32'd4;
    case (op)
      OP_CBZ:  if (rd_val == 32'd0) pc_d = pc_q + cb_off;
      OP_B:    pc_d = pc_q + b_off;
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  // Write-back select; writes aimed at X31 are dropped here.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_res;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI: wb_en = 1'b1;
      OP_LDUR: begin
        wb_en   = 1'b1;
        wb_data = mem_data_out;
      end
      default: wb_en = 1'b0;
    endcase
    if (rd_idx == 5'd31) wb_en = 1'b0;
  end

  // Architectural state: PC and register file, cleared asynchronously.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wb_en) regs_q[rd_idx] <= wb_data;
    end
  end

  // Memory strobes are suppressed while in reset so nothing is written.
  assign control_memread  = (op == OP_LDUR) && !RESET;
  assign control_memwrite = (op == OP_STUR) && !RESET;
  assign mem_address      = alu_res;
  assign mem_data_in      = rd_val;
  assign PC               = pc_q;

endmodule

// File: tb/tb_arm_cpu_core.sv
// Bench for arm_cpu_core: directed vector table, reset corners, then random
// instructions checked against an instruction-level reference model.
module tb_arm_cpu_core;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] IC;
  logic [31:0] mem_data_out;
  logic [31:0] PC;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        control_memwrite;
  logic        control_memread;

  int checks = 0;
  int errors = 0;

  arm_cpu_core dut (
    .CLOCK(CLOCK), .RESET(RESET), .IC(IC), .mem_data_out(mem_data_out),
    .PC(PC), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .control_memwrite(control_memwrite), .control_memread(control_memread)
  );

  always #5 CLOCK = ~CLOCK;

  // Environment data memory (256 words, indexed by low address byte).
  bit [31:0] dmem [256];
  always_comb mem_data_out = dmem[mem_address[7:0]];
  always @(posedge CLOCK) if (!RESET && control_memwrite) dmem[mem_address[7:0]] <= mem_data_in;

  // Reference model state.
  bit [31:0] m_regs [32];
  bit [31:0] m_mem  [256];
  bit [31:0] m_pc;

  typedef struct {
    logic [31:0] ic;
    logic [4:0]  pk;
    logic [31:0] pk_exp;
    bit          chk_a;
    logic [31:0] addr;
    logic [31:0] din;
    bit          we;
    bit          re;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: peek a register via a NOP whose Rd selects it,
  // apply the instruction, check combinational outputs, then the new PC.
  task automatic exec(input logic [4:0] pk, input logic [31:0] pk_exp, input logic [31:0] ic,
                      input bit chk_a, input logic [31:0] e_addr, input logic [31:0] e_din,
                      input bit e_we, input bit e_re, input logic [31:0] e_npc, input string tag);
    IC = {27'b0, pk};
    #1 chk({tag, ".reg"}, mem_data_in, pk_exp);
    IC = ic;
    #1;
    if (chk_a) chk({tag, ".mem_address"}, mem_address, e_addr);
    chk({tag, ".mem_data_in"}, mem_data_in, e_din);
    chk({tag, ".memwrite"}, {31'b0, control_memwrite}, {31'b0, e_we});
    chk({tag, ".memread"}, {31'b0, control_memread}, {31'b0, e_re});
    @(posedge CLOCK);
    #1 chk({tag, ".pc"}, PC, e_npc);
    @(negedge CLOCK);
  endtask

  // Instruction-level model: decode by opcode, compute effects arithmetically.
  task automatic model_step(input logic [31:0] ic, output logic [31:0] e_addr,
                            output logic [31:0] e_din, output bit e_we, output bit e_re,
                            output bit chk_a, output logic [31:0] e_npc);
    bit [31:0] a, b, r, wval;
    int        dt, cb, bo;
    int        rd;
    bit        wr;
    rd    = int'(ic[4:0]);
    a     = m_regs[ic[9:5]];
    b     = m_regs[ic[20:16]];
    dt    = $signed(ic[20:12]);
    cb    = $signed(ic[23:5]);
    bo    = $signed(ic[25:0]);
    e_din = m_regs[rd];
    e_we  = 0; e_re = 0; chk_a = 1; wr = 0; wval = 0; r = 0;
    e_npc = m_pc + 32'd4;
    if      (ic[31:21] == 11'b10001011000) begin r = a + b; wr = 1; wval = r; end
    else if (ic[31:21] == 11'b11001011000) begin r = a - b; wr = 1; wval = r; end
    else if (ic[31:21] == 11'b10001010000) begin r = a & b; wr = 1; wval = r; end
    else if (ic[31:21] == 11'b10101010000) begin r = a | b; wr = 1; wval = r; end
    else if (ic[31:22] == 10'b1001000100) begin r = a + ic[21:10]; wr = 1; wval = r; end
    else if (ic[31:22] == 10'b1101000100) begin r = a - ic[21:10]; wr = 1; wval = r; end
    else if (ic[31:21] == 11'b11111000010) begin
      r = a + dt; e_re = 1; wr = 1; wval = m_mem[r[7:0]];
    end else if (ic[31:21] == 11'b11111000000) begin
      r = a + dt; e_we = 1; m_mem[r[7:0]] = m_regs[rd];
    end else if (ic[31:24] == 8'b10110100) begin
      chk_a = 0;
      if (m_regs[rd] == 0) e_npc = m_pc + cb * 4;
    end else if (ic[31:26] == 6'b000101) begin
      chk_a = 0;
      e_npc = m_pc + bo * 4;
    end else chk_a = 0;
    e_addr = r;
    if (wr && rd != 31) m_regs[rd] = wval;
    m_pc = e_npc;
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ic, e_addr, e_din, e_npc, pk_exp;
    logic [4:0]  pk, rd, rn, rm;
    bit          e_we, e_re, chk_a;

    // Directed program: {ic, peek reg, peek value, check addr, addr, din, we, re, next PC}
    tbl[0]  = '{32'h910017E1, 5'd1,  32'd0,        1, 32'd5,        32'd0,        0, 0, 32'd4};  // ADDI X1,XZR,#5
    tbl[1]  = '{32'h91000FE2, 5'd1,  32'd5,        1, 32'd3,        32'd0,        0, 0, 32'd8};  // ADDI X2,XZR,#3
    tbl[2]  = '{32'hCB020023, 5'd2,  32'd3,        1, 32'd2,        32'd0,        0, 0, 32'd12}; // SUB X3,X1,X2
    tbl[3]  = '{32'hF8004041, 5'd3,  32'd2,        1, 32'd7,        32'd5,        1, 0, 32'd16}; // STUR X1,[X2,#4]
    tbl[4]  = '{32'hB4000060, 5'd0,  32'd0,        0, 32'd0,        32'd0,        0, 0, 32'd28}; // CBZ X0,#3 taken
    tbl[5]  = '{32'hF8404044, 5'd4,  32'd0,        1, 32'd7,        32'd0,        0, 1, 32'd32}; // LDUR X4,[X2,#4]
    tbl[6]  = '{32'h8B01003F, 5'd4,  32'd5,        1, 32'd10,       32'd0,        0, 0, 32'd36}; // ADD XZR,X1,X1
    tbl[7]  = '{32'hD10007E5, 5'd31, 32'd0,        1, 32'hFFFFFFFF, 32'd0,        0, 0, 32'd40}; // SUBI X5,XZR,#1
    tbl[8]  = '{32'h17FFFFFC, 5'd5,  32'hFFFFFFFF, 0, 32'd0,        32'd0,        0, 0, 32'd24}; // B #-4
    tbl[9]  = '{32'h17FFFFFE, 5'd31, 32'd0,        0, 32'd0,        32'd0,        0, 0, 32'd16}; // B #-2 at 24
    tbl[10] = '{32'hB4000061, 5'd1,  32'd5,        0, 32'd0,        32'd5,        0, 0, 32'd20}; // CBZ X1,#3 not taken
    tbl[11] = '{32'hAA020026, 5'd2,  32'd3,        1, 32'd7,        32'd0,        0, 0, 32'd24}; // ORR X6,X1,X2
    tbl[12] = '{32'h8A020027, 5'd6,  32'd7,        1, 32'd1,        32'd0,        0, 0, 32'd28}; // AND X7,X1,X2
    tbl[13] = '{32'h8B020028, 5'd7,  32'd1,        1, 32'd8,        32'd0,        0, 0, 32'd32}; // ADD X8,X1,X2
    tbl[14] = '{32'hCB010049, 5'd8,  32'd8,        1, 32'hFFFFFFFE, 32'd0,        0, 0, 32'd36}; // SUB X9,X2,X1
    tbl[15] = '{32'h00000009, 5'd9,  32'hFFFFFFFE, 0, 32'd0,        32'hFFFFFFFE, 0, 0, 32'd40}; // NOP

    // Power-on reset: PC and every register read 0, memory strobes gated.
    RESET = 1'b1;
    IC    = 32'd0;
    #1 chk("reset.pc", PC, 32'd0);
    for (int n = 0; n < 32; n++) begin
      IC = 32'(n);
      #1 chk($sformatf("reset.x%0d", n), mem_data_in, 32'd0);
    end
    IC = 32'hF8004041;
    #1 chk("reset.memwrite", {31'b0, control_memwrite}, 32'd0);
    IC = 32'hF8404044;
    #1 chk("reset.memread", {31'b0, control_memread}, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    IC    = 32'd0;

    for (int i = 0; i < 16; i++)
      exec(tbl[i].pk, tbl[i].pk_exp, tbl[i].ic, tbl[i].chk_a, tbl[i].addr, tbl[i].din,
           tbl[i].we, tbl[i].re, tbl[i].npc, $sformatf("vec%0d", i));

    // Mid-program reset between clock edges must clear state at once.
    @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1 chk("midreset.pc", PC, 32'd0);
    for (int n = 1; n < 10; n++) begin
      IC = 32'(n);
      #1 chk($sformatf("midreset.x%0d", n), mem_data_in, 32'd0);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    IC    = 32'd0;

    // Random program against the reference model, starting from reset state.
    m_pc = 0;
    for (int n = 0; n < 32; n++) m_regs[n] = 0;
    for (int n = 0; n < 256; n++) m_mem[n] = dmem[n];
    for (int i = 0; i < 400; i++) begin
      rd = pick_reg(); rn = pick_reg(); rm = pick_reg();
      case ($urandom_range(0, 10))
        0:  ic = {11'b10001011000, rm, 6'($urandom), rn, rd};
        1:  ic = {11'b11001011000, rm, 6'($urandom), rn, rd};
        2:  ic = {11'b10001010000, rm, 6'($urandom), rn, rd};
        3:  ic = {11'b10101010000, rm, 6'($urandom), rn, rd};
        4:  ic = {10'b1001000100, 12'($urandom), rn, rd};
        5:  ic = {10'b1101000100, 12'($urandom), rn, rd};
        6:  ic = {11'b11111000010, 9'($urandom), 2'b00, rn, rd};
        7:  ic = {11'b11111000000, 9'($urandom), 2'b00, rn, rd};
        8:  ic = {8'b10110100, 19'($urandom_range(0, 15) - 8), rd};
        9:  ic = {6'b000101, 26'($urandom_range(0, 15) - 8)};
        default: ic = $urandom;
      endcase
      pk     = 5'($urandom_range(0, 31));
      pk_exp = m_regs[pk];
      model_step(ic, e_addr, e_din, e_we, e_re, chk_a, e_npc);
      exec(pk, pk_exp, ic, chk_a, e_addr, e_din, e_we, e_re, e_npc, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
